// File: rtl/mips_multicycle.sv
// mips_multicycle: multicycle MIPS-subset core with on-chip instruction and data memory.
// Each instruction walks FETCH -> DECODE -> EXEC [-> MEM] [-> WB] and returns to FETCH.
// An illegal instruction parks the core in HALT until reset.
module mips_multicycle #(
    parameter int          IMEM_WORDS = 1024,
    parameter int          DMEM_WORDS = 256,
    parameter logic [31:0] RESET_PC   = 32'h0000_0000
) (
    input  logic                          clock,
    input  logic                          reset_n,
    input  logic                          run,
    input  logic                          imem_we,
    input  logic [$clog2(IMEM_WORDS)-1:0] imem_addr,
    input  logic [31:0]                   imem_wdata,
    output logic [31:0]                   pc,
    output logic [31:0]                   ir,
    output logic [31:0]                   alu_out,
    output logic [2:0]                    state,
    output logic                          halted
);
    localparam int IW = $clog2(IMEM_WORDS);
    localparam int DW = $clog2(DMEM_WORDS);

    localparam logic [2:0] S_FETCH  = 3'd0;
    localparam logic [2:0] S_DECODE = 3'd1;
    localparam logic [2:0] S_EXEC   = 3'd2;
    localparam logic [2:0] S_MEM    = 3'd3;
    localparam logic [2:0] S_WB     = 3'd4;
    localparam logic [2:0] S_HALT   = 3'd7;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    localparam logic [5:0] FN_ADD = 6'd32;
    localparam logic [5:0] FN_SUB = 6'd34;
    localparam logic [5:0] FN_AND = 6'd36;
    localparam logic [5:0] FN_OR  = 6'd37;
    localparam logic [5:0] FN_SLT = 6'd42;

    logic [31:0] imem [IMEM_WORDS];
    logic [31:0] dmem [DMEM_WORDS];
    logic [31:0] rf   [32];

    logic [31:0] a_q, b_q, mdr_q;
    logic        en_q;
    logic [2:0]  next_state;

    logic        ir_we, pc_we, ab_we, alu_we, mdr_we, dmem_we, rf_we;
    logic [31:0] pc_nxt, alu_nxt, rf_wdata;
    logic [4:0]  rf_waddr;

    logic [5:0]  op, funct;
    logic [4:0]  rs, rt, rd;
    logic [31:0] imm_sx;

    assign op     = ir[31:26];
    assign rs     = ir[25:21];
    assign rt     = ir[20:16];
    assign rd     = ir[15:11];
    assign funct  = ir[5:0];
    assign imm_sx = {{16{ir[15]}}, ir[15:0]};
    assign halted = (state == S_HALT);

    // R-type ALU; slt is a signed compare, add/sub wrap silently
    function automatic logic [31:0] alu_rtype(input logic [5:0] fn, input logic [31:0] x,
                                              input logic [31:0] y);
        logic signed [31:0] xs;
        logic signed [31:0] ys;
        xs = x;
        ys = y;
        case (fn)
            FN_ADD:  return x + y;
            FN_SUB:  return x - y;
            FN_AND:  return x & y;
            FN_OR:   return x | y;
            FN_SLT:  return {31'd0, (xs < ys)};
            default: return 32'd0;
        endcase
    endfunction

    function automatic logic is_legal(input logic [5:0] o, input logic [5:0] fn);
        case (o)
            OP_RTYPE: return fn inside {FN_ADD, FN_SUB, FN_AND, FN_OR, FN_SLT};
            OP_J, OP_BEQ, OP_ADDI, OP_LW, OP_SW: return 1'b1;
            default:  return 1'b0;
        endcase
    endfunction

    // Release synchroniser: the core is enabled one edge after reset_n rises
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) en_q <= 1'b0;
        else          en_q <= 1'b1;
    end

    // FSM state register
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n)  state <= S_FETCH;
        else if (en_q) state <= next_state;
    end

    // FSM next-state logic
    always_comb begin
        next_state = state;
        case (state)
            S_FETCH:  next_state = run ? S_DECODE : S_FETCH;
            S_DECODE: next_state = is_legal(op, funct) ? S_EXEC : S_HALT;
            S_EXEC: begin
                case (op)
                    OP_RTYPE, OP_ADDI: next_state = S_WB;
                    OP_LW, OP_SW:      next_state = S_MEM;
                    default:           next_state = S_FETCH;
                endcase
            end
            S_MEM:    next_state = (op == OP_LW) ? S_WB : S_FETCH;
            S_WB:     next_state = S_FETCH;
            S_HALT:   next_state = S_HALT;
            default:  next_state = S_FETCH;
        endcase
    end

    // FSM outputs: per-state datapath enables and mux selections
    always_comb begin
        ir_we    = 1'b0;
        pc_we    = 1'b0;
        ab_we    = 1'b0;
        alu_we   = 1'b0;
        mdr_we   = 1'b0;
        dmem_we  = 1'b0;
        rf_we    = 1'b0;
        pc_nxt   = pc + 32'd4;
        alu_nxt  = a_q + imm_sx;
        rf_waddr = rt;
        rf_wdata = alu_out;
        if (en_q) begin
            case (state)
                S_FETCH: begin
                    ir_we = run;
                    pc_we = run;
                end
                S_DECODE: ab_we = 1'b1;
                S_EXEC: begin
                    case (op)
                        OP_RTYPE: begin
                            alu_we  = 1'b1;
                            alu_nxt = alu_rtype(funct, a_q, b_q);
                        end
                        OP_ADDI, OP_LW, OP_SW: alu_we = 1'b1;
                        OP_BEQ: begin
                            pc_we  = (a_q == b_q);
                            pc_nxt = pc + {imm_sx[29:0], 2'b00};
                        end
                        OP_J: begin
                            pc_we  = 1'b1;
                            pc_nxt = {pc[31:28], ir[25:0], 2'b00};
                        end
                        default: ;
                    endcase
                end
                S_MEM: begin
                    mdr_we  = (op == OP_LW);
                    dmem_we = (op == OP_SW);
                end
                S_WB: begin
                    rf_we = 1'b1;
                    if (op == OP_RTYPE) rf_waddr = rd;
                    if (op == OP_LW)    rf_wdata = mdr_q;
                end
                default: ;
            endcase
        end
    end

    // Architectural PC, IR and ALU-result registers
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            pc      <= RESET_PC;
            ir      <= '0;
            alu_out <= '0;
        end else begin
            if (pc_we)  pc      <= pc_nxt;
            if (ir_we)  ir      <= imem[pc[IW+1:2]];
            if (alu_we) alu_out <= alu_nxt;
        end
    end

    // Operand and memory-data latches; pure data, never observed before being loaded
    always_ff @(posedge clock) begin
        if (ab_we) begin
            a_q <= rf[rs];
            b_q <= rf[rt];
        end
        if (mdr_we) mdr_q <= dmem[alu_out[DW+1:2]];
    end

    // Register file; $0 is never written so it always reads zero
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < 32; i++) rf[i] <= '0;
        end else if (rf_we && rf_waddr != 5'd0) begin
            rf[rf_waddr] <= rf_wdata;
        end
    end

    // Data memory write port (contents survive reset)
    always_ff @(posedge clock) begin
        if (dmem_we) dmem[alu_out[DW+1:2]] <= b_q;
    end

    // Instruction memory load port, open only while idling in FETCH
    always_ff @(posedge clock) begin
        if (imem_we && state == S_FETCH && !run) imem[imem_addr] <= imem_wdata;
    end

endmodule

// File: tb/tb_mips_multicycle.sv
// tb_mips_multicycle: directed and randomized programs checked against an ISA-level model.
module tb_mips_multicycle;
    localparam int IMEM_WORDS = 1024;
    localparam int DMEM_WORDS = 256;
    localparam int IW = 10;

    logic          clock = 1'b0;
    logic          reset_n = 1'b0;
    logic          run = 1'b0;
    logic          imem_we = 1'b0;
    logic [IW-1:0] imem_addr = '0;
    logic [31:0]   imem_wdata = '0;
    logic [31:0]   pc, ir, alu_out;
    logic [2:0]    state;
    logic          halted;

    int n_tests = 0;
    int n_fail  = 0;

    mips_multicycle #(
        .IMEM_WORDS(IMEM_WORDS),
        .DMEM_WORDS(DMEM_WORDS),
        .RESET_PC  (32'h0000_0000)
    ) dut (
        .clock     (clock),
        .reset_n   (reset_n),
        .run       (run),
        .imem_we   (imem_we),
        .imem_addr (imem_addr),
        .imem_wdata(imem_wdata),
        .pc        (pc),
        .ir        (ir),
        .alu_out   (alu_out),
        .state     (state),
        .halted    (halted)
    );

    always #5 clock = ~clock;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ISA-level model state
    logic [31:0] m_imem [IMEM_WORDS];
    logic [31:0] m_dmem [DMEM_WORDS];
    logic [31:0] m_reg  [32];
    logic [31:0] m_pc, m_ir, m_alu;
    bit          m_halt;
    logic [31:0] prog [$];
    logic [31:0] alu_hist [$];
    int          last_lat;
    int          total_cycles;
    int          fns [5] = '{32, 34, 36, 37, 42};

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual=%h expected=%h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] enc_r(input int fn, input int rd, input int rs, input int rt);
        return {6'h00, 5'(rs), 5'(rt), 5'(rd), 5'd0, 6'(fn)};
    endfunction

    function automatic logic [31:0] enc_i(input int op, input int rt, input int rs, input int imm);
        return {6'(op), 5'(rs), 5'(rt), 16'(imm)};
    endfunction

    function automatic logic [31:0] enc_j(input int tgt_word);
        return {6'h02, 26'(tgt_word)};
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 32; i++) m_reg[i] = '0;
        m_pc = 32'd0; m_ir = '0; m_alu = '0; m_halt = 1'b0;
    endtask

    // Execute one instruction architecturally; returns its expected cycle count
    task automatic model_step(output int lat);
        logic [31:0] w, sx, res, addr;
        logic [5:0]  op, fn;
        int          rs, rt, rd;
        w  = m_imem[(m_pc >> 2) % IMEM_WORDS];
        m_ir = w;
        m_pc = m_pc + 32'd4;
        op = w[31:26]; fn = w[5:0];
        rs = int'(w[25:21]); rt = int'(w[20:16]); rd = int'(w[15:11]);
        sx = {{16{w[15]}}, w[15:0]};
        res = '0;
        lat = 2;
        case (op)
            6'h00: begin
                lat = 4;
                case (fn)
                    6'd32: res = m_reg[rs] + m_reg[rt];
                    6'd34: res = m_reg[rs] - m_reg[rt];
                    6'd36: res = m_reg[rs] & m_reg[rt];
                    6'd37: res = m_reg[rs] | m_reg[rt];
                    6'd42: res = {31'd0, ($signed(m_reg[rs]) < $signed(m_reg[rt]))};
                    default: begin m_halt = 1'b1; lat = 2; end
                endcase
                if (!m_halt) begin
                    m_alu = res;
                    if (rd != 0) m_reg[rd] = res;
                end
            end
            6'h08: begin
                lat = 4; m_alu = m_reg[rs] + sx;
                if (rt != 0) m_reg[rt] = m_alu;
            end
            6'h23: begin
                lat = 5; addr = m_reg[rs] + sx; m_alu = addr;
                if (rt != 0) m_reg[rt] = m_dmem[(addr >> 2) % DMEM_WORDS];
            end
            6'h2B: begin
                lat = 4; addr = m_reg[rs] + sx; m_alu = addr;
                m_dmem[(addr >> 2) % DMEM_WORDS] = m_reg[rt];
            end
            6'h04: begin
                lat = 3;
                if (m_reg[rs] == m_reg[rt]) m_pc = m_pc + (sx << 2);
            end
            6'h02: begin
                lat = 3; m_pc = {m_pc[31:28], w[25:0], 2'b00};
            end
            default: begin m_halt = 1'b1; lat = 2; end
        endcase
    endtask

    task automatic check_reset_vals(input string tag);
        int bad;
        check({tag, "_pc"}, pc, 32'd0);
        check({tag, "_ir"}, ir, 32'd0);
        check({tag, "_alu"}, alu_out, 32'd0);
        check({tag, "_state"}, {29'd0, state}, 32'd0);
        check({tag, "_halted"}, {31'd0, halted}, 32'd0);
        bad = 0;
        for (int i = 0; i < 32; i++) if (dut.rf[i] !== 32'd0) bad++;
        check({tag, "_regs_nonzero"}, bad, 0);
    endtask

    // Assert reset, check reset values, release and check the synchronised start
    task automatic reset_dut();
        @(negedge clock);
        run = 1'b1; imem_we = 1'b0; reset_n = 1'b0;
        #1;
        check_reset_vals("reset");
        model_reset();
        @(posedge clock); @(negedge clock);
        reset_n = 1'b1;
        @(posedge clock); @(negedge clock);
        check("sync_state", {29'd0, state}, 32'd0);
        check("sync_pc", pc, 32'd0);
        run = 1'b0;
        @(posedge clock); @(negedge clock);
        check("hold_state", {29'd0, state}, 32'd0);
        check("hold_pc", pc, 32'd0);
    endtask

    task automatic load_prog();
        run = 1'b0;
        foreach (prog[i]) begin
            imem_we = 1'b1; imem_addr = IW'(i); imem_wdata = prog[i];
            m_imem[i] = prog[i];
            @(posedge clock); @(negedge clock);
        end
        imem_we = 1'b0;
    endtask

    // Single compare point: after every instruction, DUT vs model
    task automatic run_prog(input int n);
        int lat, cnt, bad;
        for (int k = 0; k < n && !m_halt; k++) begin
            run = 1'b1;
            model_step(lat);
            cnt = 0;
            do begin
                @(posedge clock); @(negedge clock);
                cnt++;
            end while (!(state == 3'd0 || state == 3'd7) && cnt < 8);
            last_lat = cnt;
            total_cycles += cnt;
            check("latency", cnt, lat);
            check("pc", pc, m_pc);
            check("ir", ir, m_ir);
            check("alu_out", alu_out, m_alu);
            check("halted", {31'd0, halted}, {31'd0, m_halt});
            check("state", {29'd0, state}, m_halt ? 32'd7 : 32'd0);
            bad = 0;
            for (int i = 0; i < 32; i++) if (dut.rf[i] !== m_reg[i]) bad++;
            check("regfile_diffs", bad, 0);
            alu_hist.push_back(alu_out);
        end
        run = 1'b0;
    endtask

    initial begin
        int bad, off, tgt, pos, r, imm;

        // Arithmetic/logic sequence
        reset_dut();
        prog = '{enc_i(8, 9, 0, 15), enc_i(8, 10, 0, 7), enc_r(36, 11, 9, 10),
                 enc_r(34, 10, 9, 11), enc_r(37, 10, 10, 11), enc_r(42, 9, 11, 10)};
        load_prog();
        alu_hist.delete(); total_cycles = 0;
        run_prog(6);
        if (alu_hist.size() == 6) begin
            check("seq_alu0", alu_hist[0], 32'd15);
            check("seq_alu1", alu_hist[1], 32'd7);
            check("seq_alu2", alu_hist[2], 32'd7);
            check("seq_alu3", alu_hist[3], 32'd8);
            check("seq_alu4", alu_hist[4], 32'd15);
            check("seq_alu5", alu_hist[5], 32'd1);
        end else begin
            check("seq_count", alu_hist.size(), 6);
        end
        check("seq_cycles", total_cycles, 24);
        check("seq_pc", pc, 32'd24);
        check("seq_t1", dut.rf[9], 32'd1);
        check("seq_t2", dut.rf[10], 32'd15);

        // Signed slt, then imem_we ignored while running
        reset_dut();
        prog = '{enc_i(8, 9, 0, -1), enc_r(42, 10, 9, 0)};
        load_prog();
        run_prog(2);
        check("slt_signed", dut.rf[10], 32'd1);
        run = 1'b1; imem_we = 1'b1; imem_addr = '0; imem_wdata = 32'hDEAD_BEEF;
        @(posedge clock); @(negedge clock);
        imem_we = 1'b0; run = 1'b0;
        check("imem_we_while_run", dut.imem[0], m_imem[0]);

        // Store then load
        reset_dut();
        prog = '{enc_i(8, 9, 0, 32'h55), enc_i(43, 9, 0, 8), enc_i(35, 10, 0, 8)};
        load_prog();
        run_prog(3);
        check("lw_value", dut.rf[10], 32'h55);
        check("lw_latency", last_lat, 5);

        // Branch-to-self loop
        reset_dut();
        prog = '{enc_i(4, 0, 0, -1)};
        load_prog();
        run_prog(4);
        check("beq_pc", pc, 32'd0);
        check("beq_latency", last_lat, 3);

        // Write to $0 discarded
        reset_dut();
        prog = '{enc_i(8, 0, 0, 5)};
        load_prog();
        run_prog(1);
        check("r0_zero", dut.rf[0], 32'd0);
        check("r0_alu", alu_out, 32'd5);

        // Illegal opcode halts; halt is frozen
        reset_dut();
        prog = '{enc_i(8, 1, 0, 5), 32'hFC00_0000};
        load_prog();
        run_prog(2);
        check("halt_state", {29'd0, state}, 32'd7);
        check("halt_flag", {31'd0, halted}, 32'd1);
        run = 1'b1; imem_we = 1'b1; imem_addr = IW'(1); imem_wdata = 32'd0;
        repeat (3) begin @(posedge clock); @(negedge clock); end
        run = 1'b0;
        repeat (2) begin @(posedge clock); @(negedge clock); end
        imem_we = 1'b0;
        check("halt_pc_frozen", pc, 32'd8);
        check("halt_ir_frozen", ir, 32'hFC00_0000);
        check("halt_still", {29'd0, state}, 32'd7);
        check("halt_imem_frozen", dut.imem[1], 32'hFC00_0000);
        check("halt_reg_kept", dut.rf[1], 32'd5);
        reset_dut();
        check("halt_cleared", {31'd0, halted}, 32'd0);

        // Illegal funct halts
        prog = '{enc_r(33, 1, 2, 3)};
        load_prog();
        run_prog(1);
        check("bad_funct_halt", {31'd0, halted}, 32'd1);

        // Reset during MEM of a store aborts the write
        reset_dut();
        prog = '{enc_i(8, 2, 0, 32'h77), enc_i(43, 2, 0, 12), enc_i(8, 1, 0, 32'h1234),
                 enc_i(43, 1, 0, 12)};
        load_prog();
        run_prog(3);
        run = 1'b1;
        repeat (3) begin @(posedge clock); @(negedge clock); end
        check("abort_in_mem", {29'd0, state}, 32'd3);
        reset_n = 1'b0;
        #1;
        check_reset_vals("abort");
        model_reset();
        @(posedge clock); @(negedge clock);
        check("abort_dmem", dut.dmem[3], 32'h77);

        // Randomized program: initialised data words, then a looping random body
        reset_dut();
        prog.delete();
        for (int w = 0; w < 16; w++) begin
            prog.push_back(enc_i(8, 1, 0, int'($urandom_range(0, 65535))));
            prog.push_back(enc_i(43, 1, 0, w * 4));
        end
        for (int i = 0; i < 64; i++) begin
            pos = 32 + i;
            r = int'($urandom_range(0, 9));
            imm = int'($urandom_range(0, 15)) * 4 + int'($urandom_range(0, 3))
                  + int'($urandom_range(0, 3)) * 1024;
            case (r)
                0, 1, 2, 3, 4:
                    prog.push_back(enc_r(fns[$urandom_range(0, 4)], int'($urandom_range(0, 7)),
                                         int'($urandom_range(0, 7)), int'($urandom_range(0, 7))));
                5: prog.push_back(enc_i(8, int'($urandom_range(0, 7)), int'($urandom_range(0, 7)),
                                        int'($urandom_range(0, 65535))));
                6: prog.push_back(enc_i(35, int'($urandom_range(0, 7)), 0, imm));
                7: prog.push_back(enc_i(43, int'($urandom_range(0, 7)), 0, imm));
                8: begin
                    off = int'($urandom_range(0, 8)) - 4;
                    if (off == -1) off = 1;
                    tgt = pos + 1 + off;
                    if (tgt < 32 || tgt > 95) off = 0;
                    prog.push_back(enc_i(4, int'($urandom_range(0, 3)),
                                         int'($urandom_range(0, 3)), off));
                end
                default: prog.push_back(enc_j(32 + int'($urandom_range(0, 63))));
            endcase
        end
        prog.push_back(enc_j(32));
        load_prog();
        run_prog(300);
        bad = 0;
        for (int i = 0; i < DMEM_WORDS; i++) if (dut.dmem[i] !== m_dmem[i]) bad++;
        check("random_dmem_diffs", bad, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
